// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL lock sequencer.
//   seq_state_t : sequencer FSM states with their fixed 2-bit debug encoding
//   sat_inc8    : 8-bit increment that holds at 255 instead of wrapping
package pll_seq_pkg;

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABILIZE = 2'd2,
        RUN       = 2'd3
    } seq_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync2.sv
// Generic two-flop bit synchronizer.
//   clk : destination clock
//   rst : synchronous active-high reset, clears both flops
//   d   : asynchronous input bit
//   q   : synchronized output, lags d by two clk edges
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset / lock sequencer. Pulses the PLL reset, waits for lock, requires
// a stable lock window, then releases the downstream core reset. Retries on
// lock timeout and restarts on lock loss or a relock request.
//   refclk          : sole clock (board reference)
//   rst             : synchronous active-high reset
//   pll_locked      : PLL lock flag, asynchronous to refclk
//   force_relock    : single-cycle request to rerun the full sequence
//   pll_rst         : PLL reset, active-high
//   sys_rst         : downstream core reset request, active-high
//   ready           : high only in RUN
//   lock_loss_count : lock losses seen in RUN, saturating at 255
//   timeout_count   : lock wait timeouts, saturating at 255
//   state           : current FSM state for debug
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 65536
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       force_relock,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] lock_loss_count,
    output logic [7:0] timeout_count,
    output logic [1:0] state
);

    localparam int MAX_AB = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ?
                            RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
    localparam int MAX_P  = (MAX_AB > LOCK_TIMEOUT_CYCLES) ? MAX_AB : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);

    seq_state_t       state_r;
    seq_state_t       next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic             locked_s;
    logic             inc_timeout_s;
    logic             inc_loss_s;
    logic             pll_rst_r;
    logic             sys_rst_r;
    logic             ready_r;
    logic [7:0]       loss_cnt_r;
    logic [7:0]       timeout_cnt_r;

    sync2 u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked),
        .q   (locked_s)
    );

    // Next-state decode and status-counter increment requests.
    always_comb begin
        next_state_s  = state_r;
        inc_timeout_s = 1'b0;
        inc_loss_s    = 1'b0;
        case (state_r)
            PLL_RESET: begin
                if (cnt_r == RST_LAST) begin
                    next_state_s = WAIT_LOCK;
                end else begin
                    next_state_s = PLL_RESET;
                end
            end
            WAIT_LOCK: begin
                if (locked_s) begin
                    next_state_s = STABILIZE;
                end else if (cnt_r == TIMEOUT_LAST) begin
                    next_state_s  = PLL_RESET;
                    inc_timeout_s = 1'b1;
                end else begin
                    next_state_s = WAIT_LOCK;
                end
            end
            STABILIZE: begin
                // A dropout here is just an unstable lock, not a timeout.
                if (!locked_s) begin
                    next_state_s = WAIT_LOCK;
                end else if (cnt_r == STABLE_LAST) begin
                    next_state_s = RUN;
                end else begin
                    next_state_s = STABILIZE;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    next_state_s = PLL_RESET;
                    inc_loss_s   = 1'b1;
                end else begin
                    next_state_s = RUN;
                end
            end
            default: begin
                next_state_s = PLL_RESET;
            end
        endcase
        // Relock wins every transition; a lock loss in the same cycle is still
        // a genuine loss and stays counted, a timeout does not.
        if (force_relock) begin
            next_state_s  = PLL_RESET;
            inc_timeout_s = 1'b0;
        end else begin
            next_state_s = next_state_s;
        end
    end

    // State, phase counter, decoded outputs and status counters.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_r       <= PLL_RESET;
            cnt_r         <= '0;
            pll_rst_r     <= 1'b1;
            sys_rst_r     <= 1'b1;
            ready_r       <= 1'b0;
            loss_cnt_r    <= 8'd0;
            timeout_cnt_r <= 8'd0;
        end else begin
            state_r   <= next_state_s;
            pll_rst_r <= (next_state_s == PLL_RESET);
            sys_rst_r <= (next_state_s != RUN);
            ready_r   <= (next_state_s == RUN);
            // A relock restarts the pulse even if already in PLL_RESET. RUN has
            // no limit, so the counter is parked there to keep it from wrapping.
            if ((next_state_s != state_r) || force_relock || (state_r == RUN)) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (inc_loss_s) begin
                loss_cnt_r <= sat_inc8(loss_cnt_r);
            end else begin
                loss_cnt_r <= loss_cnt_r;
            end
            if (inc_timeout_s) begin
                timeout_cnt_r <= sat_inc8(timeout_cnt_r);
            end else begin
                timeout_cnt_r <= timeout_cnt_r;
            end
        end
    end

    assign pll_rst         = pll_rst_r;
    assign sys_rst         = sys_rst_r;
    assign ready           = ready_r;
    assign lock_loss_count = loss_cnt_r;
    assign timeout_count   = timeout_cnt_r;
    assign state           = state_r;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with RST_PULSE_CYCLES=4,
// LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32. Cycle k means "just after the
// k-th rising edge following rst release"; expected values are hand traced.
module tb_pll_lock_sequencer;

    logic       refclk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       force_relock;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] lock_loss_count;
    logic [7:0] timeout_count;
    logic [1:0] state;

    int tests_run    = 0;
    int tests_failed = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES    (4),
        .LOCK_STABLE_CYCLES  (8),
        .LOCK_TIMEOUT_CYCLES (32)
    ) dut (
        .refclk          (refclk),
        .rst             (rst),
        .pll_locked      (pll_locked),
        .force_relock    (force_relock),
        .pll_rst         (pll_rst),
        .sys_rst         (sys_rst),
        .ready           (ready),
        .lock_loss_count (lock_loss_count),
        .timeout_count   (timeout_count),
        .state           (state)
    );

    always #10 refclk = ~refclk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    // Hold rst for two edges, check the reset values, then release rst.
    task automatic apply_reset(input string tag);
        rst          = 1'b1;
        force_relock = 1'b0;
        step(2);
        check_eq({tag, "_state"},   32'(state),           32'd0);
        check_eq({tag, "_pll_rst"}, 32'(pll_rst),         32'd1);
        check_eq({tag, "_sys_rst"}, 32'(sys_rst),         32'd1);
        check_eq({tag, "_ready"},   32'(ready),           32'd0);
        check_eq({tag, "_loss"},    32'(lock_loss_count), 32'd0);
        check_eq({tag, "_tmo"},     32'(timeout_count),   32'd0);
        rst = 1'b0;
    endtask

    task automatic wait_ready(input string tag, input int max_cycles);
        int n = 0;
        while (ready !== 1'b1 && n < max_cycles) begin
            step(1);
            n++;
        end
        check_eq(tag, 32'(ready), 32'd1);
    endtask

    task automatic lose_lock();
        pll_locked = 1'b0;
        step(3);
        pll_locked = 1'b1;
    endtask

    initial begin
        int   rises;
        logic prev_pll_rst;
        logic sys_rst_low;

        rst          = 1'b1;
        pll_locked   = 1'b0;
        force_relock = 1'b0;

        // Clean boot: lock at k=10, synced at k=12, STABILIZE k=13, RUN k=21.
        apply_reset("boot_rst");
        check_eq("boot_pll_rst_k0", 32'(pll_rst), 32'd1);
        step(3);
        check_eq("boot_pll_rst_k3", 32'(pll_rst), 32'd1);
        step(1);
        check_eq("boot_pll_rst_k4", 32'(pll_rst), 32'd0);
        check_eq("boot_state_k4",   32'(state),   32'd1);
        step(6);
        pll_locked = 1'b1;
        step(2);
        check_eq("boot_state_k12", 32'(state), 32'd1);
        step(1);
        check_eq("boot_state_k13", 32'(state), 32'd2);
        step(7);
        check_eq("boot_ready_k20", 32'(ready), 32'd0);
        step(1);
        check_eq("boot_ready_k21", 32'(ready),           32'd1);
        check_eq("boot_state_k21", 32'(state),           32'd3);
        check_eq("boot_sys_rst",   32'(sys_rst),         32'd0);
        check_eq("boot_loss",      32'(lock_loss_count), 32'd0);
        check_eq("boot_tmo",       32'(timeout_count),   32'd0);

        // Never lock: timeouts at k=36, 72, 108 (4 reset + 32 wait cycles each).
        pll_locked = 1'b0;
        apply_reset("nolock_rst");
        rises        = 0;
        prev_pll_rst = pll_rst;
        sys_rst_low  = 1'b0;
        for (int k = 1; k <= 108; k++) begin
            step(1);
            if (pll_rst && !prev_pll_rst) rises++;
            if (!sys_rst) sys_rst_low = 1'b1;
            prev_pll_rst = pll_rst;
            if (k == 35) begin
                check_eq("nolock_pll_rst_k35", 32'(pll_rst),       32'd0);
                check_eq("nolock_tmo_k35",     32'(timeout_count), 32'd0);
            end
            if (k == 36) begin
                check_eq("nolock_pll_rst_k36", 32'(pll_rst),       32'd1);
                check_eq("nolock_tmo_k36",     32'(timeout_count), 32'd1);
            end
        end
        check_eq("nolock_tmo_final",   32'(timeout_count), 32'd3);
        check_eq("nolock_repulses",    32'(rises),         32'd3);
        check_eq("nolock_sys_rst_low", 32'(sys_rst_low),   32'd0);

        // Glitch: STABILIZE from k=5, drop at cnt=5 (k=10) for one cycle,
        // back in WAIT_LOCK at k=13, STABILIZE k=14, RUN k=22.
        pll_locked = 1'b1;
        apply_reset("glitch_rst");
        step(5);
        check_eq("glitch_state_k5", 32'(state), 32'd2);
        step(5);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(2);
        check_eq("glitch_state_k13", 32'(state),         32'd1);
        check_eq("glitch_tmo_k13",   32'(timeout_count), 32'd0);
        step(1);
        check_eq("glitch_state_k14", 32'(state), 32'd2);
        step(7);
        check_eq("glitch_ready_k21", 32'(ready), 32'd0);
        step(1);
        check_eq("glitch_ready_k22", 32'(ready),           32'd1);
        check_eq("glitch_loss",      32'(lock_loss_count), 32'd0);
        check_eq("glitch_tmo",       32'(timeout_count),   32'd0);

        // Lock loss in RUN: sync delay then reset on the FSM edge.
        lose_lock();
        check_eq("loss_sys_rst", 32'(sys_rst),         32'd1);
        check_eq("loss_pll_rst", 32'(pll_rst),         32'd1);
        check_eq("loss_count1",  32'(lock_loss_count), 32'd1);
        for (int i = 0; i < 299; i++) begin
            wait_ready("sat_wait_ready", 64);
            lose_lock();
        end
        check_eq("loss_saturated", 32'(lock_loss_count), 32'd255);
        check_eq("loss_sat_tmo",   32'(timeout_count),   32'd0);

        // Relock with steady lock: PLL_RESET next edge, no counting.
        apply_reset("relock_rst");
        wait_ready("relock_wait_ready", 64);
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        check_eq("relock_state",   32'(state),           32'd0);
        check_eq("relock_pll_rst", 32'(pll_rst),         32'd1);
        check_eq("relock_ready",   32'(ready),           32'd0);
        check_eq("relock_loss",    32'(lock_loss_count), 32'd0);
        check_eq("relock_tmo",     32'(timeout_count),   32'd0);

        // Relock coinciding with the cycle the FSM sees the lock loss.
        wait_ready("relock_loss_wait", 64);
        pll_locked = 1'b0;
        step(2);
        force_relock = 1'b1;
        step(1);
        force_relock = 1'b0;
        pll_locked   = 1'b1;
        check_eq("relock_loss_state", 32'(state),           32'd0);
        check_eq("relock_loss_count", 32'(lock_loss_count), 32'd1);

        // Bring the loss count to 5, then reset from RUN.
        for (int i = 0; i < 4; i++) begin
            wait_ready("five_wait_ready", 64);
            lose_lock();
        end
        wait_ready("five_final_ready", 64);
        check_eq("five_loss", 32'(lock_loss_count), 32'd5);
        rst = 1'b1;
        step(1);
        check_eq("runrst_state",   32'(state),           32'd0);
        check_eq("runrst_pll_rst", 32'(pll_rst),         32'd1);
        check_eq("runrst_sys_rst", 32'(sys_rst),         32'd1);
        check_eq("runrst_ready",   32'(ready),           32'd0);
        check_eq("runrst_loss",    32'(lock_loss_count), 32'd0);
        check_eq("runrst_tmo",     32'(timeout_count),   32'd0);
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
